multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle MIPS control FSM. Sequences the shared instruction/data memory, register file,
//  ALU and PC through fetch/decode/execute/memory/writeback using the opcode from the
//  instruction bus decoder. Emits all datapath strobes and mux selects, and counts retired
//  instructions.
// PARAMETERS
//  CNT_W    32  width of instr_retired counter
//  ST_W      4  state encoding width
// PORTS
//  clk            in   1      rising-edge clock
//  reset          in   1      synchronous, active-high
//  opcode         in   6      instruction[31:26] from IR
//  mem_ready      in   1      memory completes current read/write this cycle
//  pc_write       out  1      unconditional PC load
//  pc_write_cond  out  1      PC load if ALU zero (beq)
//  iord           out  1      mem addr: 0=PC, 1=ALUOut
//  mem_read       out  1      memory read strobe
//  mem_write      out  1      memory write strobe
//  ir_write       out  1      IR load
//  reg_dst        out  2      00=rt, 01=rd, 10=r31
//  mem_to_reg     out  2      00=ALUOut, 01=MDR, 10=PC
//  reg_write      out  1      register file write
//  alu_src_a      out  1      0=PC, 1=A
//  alu_src_b      out  2      00=B, 01=const 1, 10=sign-ext imm, 11=sign-ext imm (branch)
//  alu_op         out  2      00=add, 01=sub, 10=use funct
//  pc_src         out  2      00=ALU result, 01=ALUOut, 10=jump target
//  illegal_op     out  1      one-cycle pulse, unsupported opcode
//  state          out  ST_W   current state (debug)
//  instr_retired  out  CNT_W  retired instruction count
// BEHAVIOUR
//  - States: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 REX=6 RWB=7 BEQ=8 ADDIEX=9
//    ADDIWB=10 JMP=11 JAL=12; codes 13-15 are unreachable and go to FETCH.
//  - reset=1: next state FETCH, instr_retired<=0. All outputs are forced 0 combinationally
//    while reset is high; state shows the registered value.
//  - Outputs are Moore, decoded from state, except the mem_ready gating noted below.
//    Unlisted outputs are 0.
//  - FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
//    ir_write=pc_write=mem_ready. Holds until mem_ready, then goes to DECODE.
//  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Next state:
//    0x00->REX, 0x23/0x2B->MEMADR, 0x04->BEQ, 0x08->ADDIEX, 0x02->JMP, 0x03->JAL;
//    any other opcode -> illegal_op=1 this cycle, then FETCH, not counted.
//  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: MEMRD if lw, MEMWR if sw.
//  - MEMRD: mem_read=1, iord=1. Holds until mem_ready, then goes to MEMWB.
//  - MEMWB: reg_write=1, reg_dst=00, mem_to_reg=01.
//  - MEMWR: mem_write=1, iord=1. Holds until mem_ready; mem_write stays high while holding.
//  - REX: alu_src_a=1, alu_src_b=00, alu_op=10. RWB: reg_write=1, reg_dst=01, mem_to_reg=00.
//  - BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01.
//  - ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. ADDIWB: reg_write=1, reg_dst=00,
//    mem_to_reg=00.
//  - JMP: pc_write=1, pc_src=10.
//  - JAL: pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10. PC already holds
//    PC+1 from FETCH.
//  - Completing states MEMWB, MEMWR(with mem_ready), RWB, BEQ, ADDIWB, JMP and JAL return to
//    FETCH and increment instr_retired by 1. The counter wraps from all-ones to 0.
//  - Latency with mem_ready always 1: lw=5, sw=4, R=4, addi=4, beq=3, j=3, jal=3 cycles.
//  - Reset mid-instruction: any in-flight write strobe drops the same cycle. FETCH follows.
//  - opcode is sampled only in DECODE and MEMADR; changes in other states are ignored.
// TESTING
//  - reset held 3 cycles with mem_ready=1 -> all outputs 0 during reset; first cycle after:
//    state=0, mem_read=1, ir_write=1.
//  - lw (opcode 0x23), mem_ready=1 -> states 0,1,2,3,4,0; reg_write only in state 4 with
//    mem_to_reg=01; instr_retired 0->1.
//  - sw (0x2B), mem_ready low 2 cycles in MEMWR -> mem_write high 3 cycles, reg_write never
//    1, retire on the 3rd MEMWR cycle.
//  - Sequence R(0x00), beq(0x04), jal(0x03) -> 4+3+3 cycles; beq asserts pc_write_cond
//    with alu_op=01; jal asserts reg_dst=10; instr_retired=3.
//  - opcode 0x3F -> illegal_op pulse in DECODE, then state 0, instr_retired unchanged.
//  - Force instr_retired to 0xFFFFFFFF, complete j (0x02) -> counter=0; reset in MEMRD ->
//    mem_read=0 same cycle, FETCH next.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback and
// drives every datapath strobe and mux select; also counts retired instructions.
module multicycle_ctrl #(
  parameter int CNT_W = 32,
  parameter int ST_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             illegal_op,
  output logic [ST_W-1:0]  state,
  output logic [CNT_W-1:0] instr_retired
);

  typedef enum logic [ST_W-1:0] {
    FETCH  = ST_W'(0),
    DECODE = ST_W'(1),
    MEMADR = ST_W'(2),
    MEMRD  = ST_W'(3),
    MEMWB  = ST_W'(4),
    MEMWR  = ST_W'(5),
    REX    = ST_W'(6),
    RWB    = ST_W'(7),
    BEQ    = ST_W'(8),
    ADDIEX = ST_W'(9),
    ADDIWB = ST_W'(10),
    JMP    = ST_W'(11),
    JAL    = ST_W'(12)
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             retire;
  logic             illegal;

  // Moore decode results before the reset override
  logic       pc_write_m;
  logic       pc_write_cond_m;
  logic       iord_m;
  logic       mem_read_m;
  logic       mem_write_m;
  logic       ir_write_m;
  logic [1:0] reg_dst_m;
  logic [1:0] mem_to_reg_m;
  logic       reg_write_m;
  logic       alu_src_a_m;
  logic [1:0] alu_src_b_m;
  logic [1:0] alu_op_m;
  logic [1:0] pc_src_m;

  always_comb begin
    state_d = FETCH;
    retire  = 1'b0;
    illegal = 1'b0;
    case (state_q)
      FETCH:  state_d = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_RTYPE:      state_d = REX;
          OP_LW, OP_SW:  state_d = MEMADR;
          OP_BEQ:        state_d = BEQ;
          OP_ADDI:       state_d = ADDIEX;
          OP_J:          state_d = JMP;
          OP_JAL:        state_d = JAL;
          default: begin
            state_d = FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      MEMADR: state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  state_d = mem_ready ? MEMWB : MEMRD;
      MEMWB: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      MEMWR: begin
        state_d = mem_ready ? FETCH : MEMWR;
        retire  = mem_ready;
      end
      REX:    state_d = RWB;
      ADDIEX: state_d = ADDIWB;
      RWB, BEQ, ADDIWB, JMP, JAL: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (retire) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    pc_write_m      = 1'b0;
    pc_write_cond_m = 1'b0;
    iord_m          = 1'b0;
    mem_read_m      = 1'b0;
    mem_write_m     = 1'b0;
    ir_write_m      = 1'b0;
    reg_dst_m       = 2'b00;
    mem_to_reg_m    = 2'b00;
    reg_write_m     = 1'b0;
    alu_src_a_m     = 1'b0;
    alu_src_b_m     = 2'b00;
    alu_op_m        = 2'b00;
    pc_src_m        = 2'b00;
    case (state_q)
      FETCH: begin
        // PC+1 and IR load both wait for the memory to return the instruction
        mem_read_m  = 1'b1;
        alu_src_b_m = 2'b01;
        ir_write_m  = mem_ready;
        pc_write_m  = mem_ready;
      end
      DECODE: begin
        alu_src_b_m = 2'b11;
      end
      MEMADR: begin
        alu_src_a_m = 1'b1;
        alu_src_b_m = 2'b10;
      end
      MEMRD: begin
        mem_read_m = 1'b1;
        iord_m     = 1'b1;
      end
      MEMWB: begin
        reg_write_m  = 1'b1;
        mem_to_reg_m = 2'b01;
      end
      MEMWR: begin
        mem_write_m = 1'b1;
        iord_m      = 1'b1;
      end
      REX: begin
        alu_src_a_m = 1'b1;
        alu_op_m    = 2'b10;
      end
      RWB: begin
        reg_write_m = 1'b1;
        reg_dst_m   = 2'b01;
      end
      BEQ: begin
        alu_src_a_m     = 1'b1;
        alu_op_m        = 2'b01;
        pc_write_cond_m = 1'b1;
        pc_src_m        = 2'b01;
      end
      ADDIEX: begin
        alu_src_a_m = 1'b1;
        alu_src_b_m = 2'b10;
      end
      ADDIWB: begin
        reg_write_m = 1'b1;
      end
      JMP: begin
        pc_write_m = 1'b1;
        pc_src_m   = 2'b10;
      end
      JAL: begin
        // the PC already holds the return address, written to r31 as the jump lands
        pc_write_m   = 1'b1;
        pc_src_m     = 2'b10;
        reg_write_m  = 1'b1;
        reg_dst_m    = 2'b10;
        mem_to_reg_m = 2'b10;
      end
      default: begin
        pc_write_m = 1'b0;
      end
    endcase
  end

  // reset kills every strobe in the same cycle so no in-flight write lands
  assign pc_write      = reset ? 1'b0  : pc_write_m;
  assign pc_write_cond = reset ? 1'b0  : pc_write_cond_m;
  assign iord          = reset ? 1'b0  : iord_m;
  assign mem_read      = reset ? 1'b0  : mem_read_m;
  assign mem_write     = reset ? 1'b0  : mem_write_m;
  assign ir_write      = reset ? 1'b0  : ir_write_m;
  assign reg_dst       = reset ? 2'b00 : reg_dst_m;
  assign mem_to_reg    = reset ? 2'b00 : mem_to_reg_m;
  assign reg_write     = reset ? 1'b0  : reg_write_m;
  assign alu_src_a     = reset ? 1'b0  : alu_src_a_m;
  assign alu_src_b     = reset ? 2'b00 : alu_src_b_m;
  assign alu_op        = reset ? 2'b00 : alu_op_m;
  assign pc_src        = reset ? 2'b00 : pc_src_m;
  assign illegal_op    = reset ? 1'b0  : illegal;
  assign instr_retired = reset ? '0    : cnt_q;
  assign state         = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl; a second instance with a 2-bit counter covers wrap.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_ready;
  logic [5:0]  opcode;

  logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic [1:0]  reg_dst, mem_to_reg, alu_src_b, alu_op, pc_src;
  logic        reg_write, alu_src_a, illegal_op;
  logic [3:0]  state;
  logic [31:0] instr_retired;

  logic        n_pc_write, n_pc_write_cond, n_iord, n_mem_read, n_mem_write, n_ir_write;
  logic [1:0]  n_reg_dst, n_mem_to_reg, n_alu_src_b, n_alu_op, n_pc_src;
  logic        n_reg_write, n_alu_src_a, n_illegal_op;
  logic [3:0]  n_state;
  logic [1:0]  n_instr_retired;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(32), .ST_W(4)) u_dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_src(pc_src), .illegal_op(illegal_op), .state(state),
    .instr_retired(instr_retired)
  );

  multicycle_ctrl #(.CNT_W(2), .ST_W(4)) u_dut_narrow (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(n_pc_write), .pc_write_cond(n_pc_write_cond), .iord(n_iord),
    .mem_read(n_mem_read), .mem_write(n_mem_write), .ir_write(n_ir_write),
    .reg_dst(n_reg_dst), .mem_to_reg(n_mem_to_reg), .reg_write(n_reg_write),
    .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b), .alu_op(n_alu_op),
    .pc_src(n_pc_src), .illegal_op(n_illegal_op), .state(n_state),
    .instr_retired(n_instr_retired)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [50:0] outs;
    reset = 1'b1; mem_ready = 1'b1; opcode = 6'h23;
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      outs = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_dst,
              mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op,
              instr_retired};
      tests++;
      if (outs !== 51'd0) begin
        fails++; $display("FAIL reset_outs[%0d]: got %0h want 0", i, outs);
      end
    end
    tests++;
    if (state !== 4'd0) begin
      fails++; $display("FAIL reset_state: got %0d want 0", state);
    end
    reset = 1'b0; #1;
    tests++;
    if ({state, mem_read, ir_write, pc_write, iord, alu_src_b} !== {4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01}) begin
      fails++; $display("FAIL first_fetch: got st=%0d mr=%b irw=%b pcw=%b iord=%b srcb=%b want st=0 mr=1 irw=1 pcw=1 iord=0 srcb=01",
                        state, mem_read, ir_write, pc_write, iord, alu_src_b);
    end
  endtask

  task automatic test_lw();
    int         est[5] = '{0, 1, 2, 3, 4};
    logic [5:0] op[5]  = '{6'h3F, 6'h23, 6'h23, 6'h2B, 6'h04};
    logic       rw[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      opcode = op[i]; #1;
      tests++;
      if (state !== 4'(est[i])) begin
        fails++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, est[i]);
      end
      tests++;
      if (reg_write !== rw[i]) begin
        fails++; $display("FAIL lw_reg_write[%0d]: got %b want %b", i, reg_write, rw[i]);
      end
      if (i == 3) begin
        tests++;
        if ({mem_read, iord} !== 2'b11) begin
          fails++; $display("FAIL lw_memrd: got mr=%b iord=%b want 1 1", mem_read, iord);
        end
      end
      if (i == 4) begin
        tests++;
        if ({mem_to_reg, reg_dst} !== 4'b0100) begin
          fails++; $display("FAIL lw_wb_sel: got m2r=%b dst=%b want 01 00", mem_to_reg, reg_dst);
        end
      end
      cyc();
    end
    #1;
    tests++;
    if ({state, instr_retired} !== {4'd0, 32'd1}) begin
      fails++; $display("FAIL lw_done: got st=%0d cnt=%0d want st=0 cnt=1", state, instr_retired);
    end
  endtask

  task automatic test_sw_wait();
    int   est[6] = '{0, 1, 2, 5, 5, 5};
    logic mr[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic mw[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    opcode = 6'h2B;
    for (int i = 0; i < 6; i++) begin
      mem_ready = mr[i]; #1;
      tests++;
      if ({state, mem_write, reg_write} !== {4'(est[i]), mw[i], 1'b0}) begin
        fails++; $display("FAIL sw_cycle[%0d]: got st=%0d mw=%b rw=%b want st=%0d mw=%b rw=0",
                          i, state, mem_write, reg_write, est[i], mw[i]);
      end
      if (i == 5) begin
        tests++;
        if (instr_retired !== 32'd1) begin
          fails++; $display("FAIL sw_cnt_before: got %0d want 1", instr_retired);
        end
      end
      cyc();
    end
    mem_ready = 1'b1; #1;
    tests++;
    if ({state, mem_write, instr_retired} !== {4'd0, 1'b0, 32'd2}) begin
      fails++; $display("FAIL sw_done: got st=%0d mw=%b cnt=%0d want st=0 mw=0 cnt=2",
                        state, mem_write, instr_retired);
    end
  endtask

  task automatic test_back_to_back();
    int         est[10] = '{0, 1, 6, 7, 0, 1, 8, 0, 1, 12};
    logic [5:0] op[10]  = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h04, 6'h04, 6'h04, 6'h03, 6'h03, 6'h03};
    mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      opcode = op[i]; #1;
      tests++;
      if (state !== 4'(est[i])) begin
        fails++; $display("FAIL seq_state[%0d]: got %0d want %0d", i, state, est[i]);
      end
      if (i == 2) begin
        tests++;
        if ({alu_src_a, alu_src_b, alu_op} !== 5'b1_00_10) begin
          fails++; $display("FAIL rex_ctl: got a=%b b=%b op=%b want 1 00 10", alu_src_a, alu_src_b, alu_op);
        end
      end
      if (i == 3) begin
        tests++;
        if ({reg_write, reg_dst, mem_to_reg} !== 5'b1_01_00) begin
          fails++; $display("FAIL rwb_ctl: got rw=%b dst=%b m2r=%b want 1 01 00", reg_write, reg_dst, mem_to_reg);
        end
      end
      if (i == 4 || i == 7) begin
        tests++;
        if (instr_retired !== ((i == 4) ? 32'd3 : 32'd4)) begin
          fails++; $display("FAIL seq_cnt[%0d]: got %0d want %0d", i, instr_retired, (i == 4) ? 3 : 4);
        end
      end
      if (i == 6) begin
        tests++;
        if ({pc_write_cond, alu_op, pc_src, alu_src_a, pc_write} !== 7'b1_01_01_1_0) begin
          fails++; $display("FAIL beq_ctl: got pwc=%b op=%b src=%b a=%b pcw=%b want 1 01 01 1 0",
                            pc_write_cond, alu_op, pc_src, alu_src_a, pc_write);
        end
      end
      if (i == 9) begin
        tests++;
        if ({pc_write, pc_src, reg_write, reg_dst, mem_to_reg} !== 8'b1_10_1_10_10) begin
          fails++; $display("FAIL jal_ctl: got pcw=%b src=%b rw=%b dst=%b m2r=%b want 1 10 1 10 10",
                            pc_write, pc_src, reg_write, reg_dst, mem_to_reg);
        end
      end
      cyc();
    end
    #1;
    tests++;
    if ({state, instr_retired} !== {4'd0, 32'd5}) begin
      fails++; $display("FAIL seq_done: got st=%0d cnt=%0d want st=0 cnt=5", state, instr_retired);
    end
  endtask

  task automatic test_illegal();
    int   est[3] = '{0, 0, 1};
    logic mr[3]  = '{1'b0, 1'b1, 1'b1};
    logic ill[3] = '{1'b0, 1'b0, 1'b1};
    logic irw[3] = '{1'b0, 1'b1, 1'b0};
    opcode = 6'h3F;
    for (int i = 0; i < 3; i++) begin
      mem_ready = mr[i]; #1;
      tests++;
      if ({state, illegal_op, ir_write, pc_write} !== {4'(est[i]), ill[i], irw[i], irw[i]}) begin
        fails++; $display("FAIL illegal_cycle[%0d]: got st=%0d ill=%b irw=%b pcw=%b want st=%0d ill=%b irw=%b pcw=%b",
                          i, state, illegal_op, ir_write, pc_write, est[i], ill[i], irw[i], irw[i]);
      end
      cyc();
    end
    mem_ready = 1'b1; #1;
    tests++;
    if ({state, illegal_op, instr_retired} !== {4'd0, 1'b0, 32'd5}) begin
      fails++; $display("FAIL illegal_done: got st=%0d ill=%b cnt=%0d want st=0 ill=0 cnt=5",
                        state, illegal_op, instr_retired);
    end
  endtask

  task automatic test_wrap();
    int         est[3]   = '{0, 1, 11};
    logic [1:0] n_exp[3] = '{2'd2, 2'd3, 2'd0};
    int         w_exp[3] = '{6, 7, 8};
    mem_ready = 1'b1; opcode = 6'h02;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 3; i++) begin
        #1;
        tests++;
        if (state !== 4'(est[i])) begin
          fails++; $display("FAIL j_state[%0d.%0d]: got %0d want %0d", k, i, state, est[i]);
        end
        if (i == 2) begin
          tests++;
          if ({pc_write, pc_src, reg_write} !== 4'b1_10_0) begin
            fails++; $display("FAIL j_ctl[%0d]: got pcw=%b src=%b rw=%b want 1 10 0", k, pc_write, pc_src, reg_write);
          end
        end
        cyc();
      end
      #1;
      tests++;
      if ({n_instr_retired, instr_retired} !== {n_exp[k], 32'(w_exp[k])}) begin
        fails++; $display("FAIL wrap_cnt[%0d]: got narrow=%0d wide=%0d want narrow=%0d wide=%0d",
                          k, n_instr_retired, instr_retired, n_exp[k], w_exp[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int   est[4] = '{0, 1, 2, 3};
    logic mr[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    opcode = 6'h23;
    for (int i = 0; i < 4; i++) begin
      mem_ready = mr[i]; #1;
      tests++;
      if (state !== 4'(est[i])) begin
        fails++; $display("FAIL mid_lw_state[%0d]: got %0d want %0d", i, state, est[i]);
      end
      cyc();
    end
    #1;
    tests++;
    if ({state, mem_read, iord} !== {4'd3, 1'b1, 1'b1}) begin
      fails++; $display("FAIL mid_memrd_hold: got st=%0d mr=%b iord=%b want 3 1 1", state, mem_read, iord);
    end
    reset = 1'b1; #1;
    tests++;
    if ({state, mem_read, iord, instr_retired} !== {4'd3, 1'b0, 1'b0, 32'd0}) begin
      fails++; $display("FAIL mid_memrd_drop: got st=%0d mr=%b iord=%b cnt=%0d want 3 0 0 0",
                        state, mem_read, iord, instr_retired);
    end
    cyc();
    reset = 1'b0; mem_ready = 1'b1; #1;
    tests++;
    if ({state, mem_read, instr_retired} !== {4'd0, 1'b1, 32'd0}) begin
      fails++; $display("FAIL mid_after_lw: got st=%0d mr=%b cnt=%0d want 0 1 0", state, mem_read, instr_retired);
    end
    opcode = 6'h2B;
    for (int i = 0; i < 3; i++) cyc();
    mem_ready = 1'b0; #1;
    tests++;
    if ({state, mem_write} !== {4'd5, 1'b1}) begin
      fails++; $display("FAIL mid_memwr: got st=%0d mw=%b want 5 1", state, mem_write);
    end
    reset = 1'b1; mem_ready = 1'b1; #1;
    tests++;
    if ({state, mem_write} !== {4'd5, 1'b0}) begin
      fails++; $display("FAIL mid_memwr_drop: got st=%0d mw=%b want 5 0", state, mem_write);
    end
    cyc();
    reset = 1'b0; #1;
    tests++;
    if ({state, instr_retired, n_instr_retired} !== {4'd0, 32'd0, 2'd0}) begin
      fails++; $display("FAIL mid_after_sw: got st=%0d cnt=%0d ncnt=%0d want 0 0 0",
                        state, instr_retired, n_instr_retired);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout at %0t want run complete", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; mem_ready = 1'b1; opcode = 6'h00;
    test_reset();
    test_lw();
    test_sw_wait();
    test_back_to_back();
    test_illegal();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
